// File: rtl/spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_controller: SPI master, one frame per tx_en, modes 0-3, MSB first.  |
// | Optional: SPI_CONTROLLER_PARITY_EN adds sticky parity_err output.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module spi_controller #(
  parameter int BUS_LENGTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic [BUS_LENGTH-1:0] data_in,
  input  logic                  POCI,
  output logic [BUS_LENGTH-1:0] data_out,
  output logic                  PICO,
  output logic                  SCK,
  output logic                  CS
`ifdef SPI_CONTROLLER_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int c_CNT_W = $clog2(2 * CLK_DIV);
  localparam int c_TOG_W = $clog2(2 * BUS_LENGTH + 1);
  localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_END  = c_CNT_W'(2 * CLK_DIV - 1);
  localparam logic [c_TOG_W-1:0] c_TOG_LAST = c_TOG_W'(2 * BUS_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [c_CNT_W-1:0]     cnt_q, cnt_d;
  logic [c_TOG_W-1:0]     tog_q, tog_d;
  logic                   sck_q, sck_d;
  logic                   cs_q, cs_d;
  logic                   cpha_q, cpha_d;
  logic                   smp_q, smp_d;
  logic [BUS_LENGTH-1:0]  tx_q, tx_d;
  logic [BUS_LENGTH-1:0]  rx_q, rx_d;
  logic [BUS_LENGTH-1:0]  dout_q, dout_d;
  logic                   edge_now;
`ifdef SPI_CONTROLLER_PARITY_EN
  logic                   txpar_q, txpar_d;
  logic                   perr_q, perr_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      cpha_q  <= 1'b0;
      smp_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
`ifdef SPI_CONTROLLER_PARITY_EN
      txpar_q <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      cpha_q  <= cpha_d;
      smp_q   <= smp_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
`ifdef SPI_CONTROLLER_PARITY_EN
      txpar_q <= txpar_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    cpha_d   = cpha_q;
    smp_d    = smp_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    edge_now = 1'b0;
`ifdef SPI_CONTROLLER_PARITY_EN
    txpar_d  = txpar_q;
    perr_d   = perr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cs_d  = 1'b1;
        sck_d = CPOL;
        cnt_d = '0;
        tog_d = '0;
        if (tx_en) begin
          cpha_d  = CPHA;
          tx_d    = data_in;
          smp_d   = 1'b0;
          cs_d    = 1'b0;
          state_d = S_SETUP;
`ifdef SPI_CONTROLLER_PARITY_EN
          txpar_d = ^data_in;
`endif
        end
      end
      // The first SCK edge coincides with SETUP exit, one half-period after CS falls.
      S_SETUP: begin
        if (cnt_q == c_HALF_END) begin
          edge_now = 1'b1;
          cnt_d    = '0;
          state_d  = S_XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XFER: begin
        if (cnt_q == c_HALF_END) begin
          edge_now = 1'b1;
          cnt_d    = '0;
          if (tog_q == c_TOG_LAST) state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == c_HALF_END) begin
          dout_d  = rx_q;
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
`ifdef SPI_CONTROLLER_PARITY_EN
          perr_d  = perr_q | (txpar_q ^ (^rx_q));
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        cs_d = 1'b1;
        if (cnt_q == c_GAP_END) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sampling edge is rising for CPHA=0 and falling for CPHA=1, whatever CPOL is.
    if (edge_now) begin
      sck_d = ~sck_q;
      tog_d = tog_q + 1'b1;
      if (sck_d == ~cpha_q) begin
        rx_d  = {rx_q[BUS_LENGTH-2:0], POCI};
        smp_d = 1'b1;
      end else if (smp_q) begin
        tx_d = {tx_q[BUS_LENGTH-2:0], 1'b0};
      end
    end
  end

  assign SCK      = (state_q == S_IDLE) ? CPOL : sck_q;
  assign CS       = cs_q;
  assign PICO     = tx_q[BUS_LENGTH-1];
  assign data_out = dout_q;
`ifdef SPI_CONTROLLER_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_spi_controller: directed bench with an SPI peripheral model.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       CPOL;
  logic       CPHA;
  logic [7:0] data_in;
  logic       POCI = 1'b0;
  logic [7:0] data_out;
  logic       PICO;
  logic       SCK;
  logic       CS;
`ifdef SPI_CONTROLLER_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_controller #(
    .BUS_LENGTH (8),
    .CLK_DIV    (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .CPOL       (CPOL),
    .CPHA       (CPHA),
    .data_in    (data_in),
    .POCI       (POCI),
    .data_out   (data_out),
    .PICO       (PICO),
    .SCK        (SCK),
    .CS         (CS)
`ifdef SPI_CONTROLLER_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  // Peripheral: samples PICO on the same edge as the master, drives POCI on the other.
  logic [7:0] s_word = 8'h00;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic       s_cpha = 1'b0;
  logic       s_smp = 1'b0;
  logic       cs_prev = 1'b1;
  logic       sck_prev = 1'b0;
  time        t_fall, t_first, t_second, t_last, t_rise;
  int         n_edges = 0;

  always @(SCK or CS) begin
    if (CS === 1'b0 && cs_prev !== 1'b0) begin
      s_tx    = s_word;
      POCI    = s_word[7];
      s_smp   = 1'b0;
      s_rx    = 8'h00;
      n_edges = 0;
      t_fall  = $time;
    end else if (CS === 1'b0 && SCK !== sck_prev) begin
      n_edges++;
      if (n_edges == 1) t_first = $time;
      if (n_edges == 2) t_second = $time;
      t_last = $time;
      if (SCK === ~s_cpha) begin
        s_rx  = {s_rx[6:0], PICO};
        s_smp = 1'b1;
      end else if (s_smp) begin
        s_tx = {s_tx[6:0], 1'b0};
        POCI = s_tx[7];
      end
    end
    if (CS === 1'b1 && cs_prev === 1'b0) t_rise = $time;
    cs_prev  = CS;
    sck_prev = SCK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string tag);
    int i = 0;
    while (CS !== lvl && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(CS), 32'(lvl));
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] din,
                           input logic [7:0] pw, input string tag);
    CPOL    = m[1];
    CPHA    = m[0];
    s_cpha  = m[0];
    data_in = din;
    s_word  = pw;
    tx_en   = 1'b1;
    @(negedge clk);
    check({tag, "_start"}, 32'(CS), 32'd0);
    tx_en = 1'b0;
    wait_cs(1'b1, 200, {tag, "_end"});
    @(negedge clk);
    check({tag, "_dout"}, 32'(data_out), 32'(pw));
    check({tag, "_periph"}, 32'(s_rx), 32'(din));
    check({tag, "_sck_idle"}, 32'(SCK), 32'(m[1]));
    repeat (12) @(negedge clk);
  endtask

  logic [7:0] mw [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] sw [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    rst = 1'b1; tx_en = 1'b0; CPOL = 1'b0; CPHA = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(CS), 32'd1);
    check("rst_sck", 32'(SCK), 32'd0);
    check("rst_pico", 32'(PICO), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    CPOL = 1'b1;
    #1 check("rst_sck_cpol", 32'(SCK), 32'd1);
    CPOL = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frames, A5 out / 5A in, every mode
    for (int m = 0; m < 4; m++) begin
      run_frame(2'(m), 8'hA5, 8'h5A, $sformatf("mode%0d", m));
      if (m == 0) begin
        check("t_cs_to_first", 32'(t_first - t_fall), 32'd40);
        check("t_half_period", 32'(t_second - t_first), 32'd40);
        check("n_toggles", 32'(n_edges), 32'd16);
        check("t_last_to_cs", 32'(t_rise - t_last), 32'd40);
      end
    end

    // Back-to-back frames with tx_en held; inputs disturbed mid-frame
    for (int m = 0; m < 4; m++) begin
      CPOL = m[1]; CPHA = m[0]; s_cpha = m[0];
      data_in = mw[0]; s_word = sw[0]; tx_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        wait_cs(1'b0, 100, $sformatf("b2b%0d_%0d_start", m, k));
        if (k > 0) check($sformatf("b2b%0d_%0d_hold", m, k), 32'(data_out), 32'(sw[k-1]));
        data_in = (k < 3) ? mw[k+1] : 8'h00;
        s_word  = (k < 3) ? sw[k+1] : 8'h00;
        CPOL = ~CPOL;
        CPHA = ~CPHA;
        if (k == 3) tx_en = 1'b0;
        repeat (20) @(negedge clk);
        CPOL = m[1];
        CPHA = m[0];
        wait_cs(1'b1, 200, $sformatf("b2b%0d_%0d_end", m, k));
        @(negedge clk);
        check($sformatf("b2b%0d_%0d_dout", m, k), 32'(data_out), 32'(sw[k]));
        check($sformatf("b2b%0d_%0d_periph", m, k), 32'(s_rx), 32'(mw[k]));
      end
      repeat (20) @(negedge clk);
      check($sformatf("b2b%0d_stop", m), 32'(CS), 32'd1);
    end

    // Reset mid-frame in mode 2
    CPOL = 1'b1; CPHA = 1'b0; s_cpha = 1'b0;
    data_in = 8'h3C; s_word = 8'hC3; tx_en = 1'b1;
    wait_cs(1'b0, 10, "rstmid_start");
    tx_en = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_cs", 32'(CS), 32'd1);
    check("rstmid_sck", 32'(SCK), 32'd1);
    check("rstmid_dout", 32'(data_out), 32'd0);
    check("rstmid_pico", 32'(PICO), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(2'd2, 8'h3C, 8'hC3, "post_rst");

`ifdef SPI_CONTROLLER_PARITY_EN
    check("par_clean", 32'(parity_err), 32'd0);
    run_frame(2'd0, 8'hB6, 8'hB6, "par_ok");
    check("par_ok_flag", 32'(parity_err), 32'd0);
    run_frame(2'd0, 8'hB6, 8'hB7, "par_bad");
    check("par_bad_flag", 32'(parity_err), 32'd1);
    run_frame(2'd0, 8'hB6, 8'hB6, "par_sticky");
    check("par_sticky_flag", 32'(parity_err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("par_rst_flag", 32'(parity_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter BUS_LENGTH, default 8: bits per frame.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per SCK half-period (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tx_en, input, 1 bit: level request; frames repeat while high.
REQ-006 SHALL have port CPOL, input, 1 bit: SCK idle level.
REQ-007 SHALL have port CPHA, input, 1 bit: 0 = sample on SCK rising edge and drive on falling; 1 = drive on rising and sample on falling.
REQ-008 SHALL have port data_in, input, BUS_LENGTH bits: word to transmit.
REQ-009 SHALL have port POCI, input, 1 bit: serial data from the peripheral.
REQ-010 SHALL have port data_out, output, BUS_LENGTH bits: last complete received word.
REQ-011 SHALL have port PICO, output, 1 bit: serial data to the peripheral, MSB first.
REQ-012 SHALL have port SCK, output, 1 bit: serial clock.
REQ-013 SHALL have port CS, output, 1 bit: active-low chip select.

Function
REQ-014 SHALL implement the FSM IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
REQ-015 IDLE: CS=1 and SCK=CPOL, updated every clk; if tx_en=1, latch data_in, CPOL and CPHA, drive PICO=data_in[BUS_LENGTH-1], set CS=0, and go to SETUP.
REQ-016 SETUP SHALL last CLK_DIV clks with SCK at the latched CPOL, then go to XFER.
REQ-017 XFER SHALL toggle SCK every CLK_DIV clks, exactly 2*BUS_LENGTH toggles, ending at the CPOL level.
REQ-018 On each sampling edge (rising if CPHA=0, falling if CPHA=1), shift POCI into the receive register LSB, giving BUS_LENGTH samples per frame.
REQ-019 On each drive edge that follows at least one sampling edge, PICO SHALL present the next lower bit; a drive edge before the first sampling edge leaves PICO unchanged.
REQ-020 After the final toggle, HOLD SHALL last CLK_DIV clks, with CS still 0.
REQ-021 At HOLD exit, data_out SHALL load the received word, CS=1, and the FSM goes to GAP.
REQ-022 GAP SHALL last 2*CLK_DIV clks with CS=1 and SCK=CPOL, then return to IDLE.
REQ-023 Back-to-back frames: if tx_en is still 1 in IDLE, the next frame starts on the same clk using the current data_in.
REQ-024 Deasserting tx_en mid-frame SHALL NOT abort the frame; the frame completes normally.
REQ-025 CPOL, CPHA and data_in changes mid-frame SHALL be ignored until the next frame's latch.
REQ-026 data_out SHALL hold its value between frame completions.

Reset
REQ-027 rst=1 SHALL immediately force: FSM=IDLE, CS=1, SCK=CPOL, PICO=0, data_out=0, counters=0.
REQ-028 rst asserted mid-frame SHALL abandon the frame without updating data_out.
REQ-029 After rst deasserts, the first frame SHALL start on the first clk edge with tx_en=1.

Configuration
REQ-030 With SPI_CONTROLLER_PARITY_EN defined, SHALL add output parity_err (1 bit), reset to 0.
REQ-031 With SPI_CONTROLLER_PARITY_EN defined, parity_err SHALL be set at HOLD exit when XOR-reduce(transmitted word) differs from XOR-reduce(received word).
REQ-032 parity_err SHALL be sticky and cleared only by rst.
REQ-033 Without SPI_CONTROLLER_PARITY_EN, parity_err and its logic SHALL be absent.

Verification
REQ-034 Each mode 0-3, loopback to an SPI peripheral, data_in=0xA5, peripheral word 0x5A, tx_en high 2000 ns -> peripheral receives 0xA5, data_out=0x5A.
REQ-035 Each mode, tx_en held high, data_in 0x11/0x22/0x33/0x44 changed every 2050 ns, peripheral 0xAA/0xBB/0xCC/0xDD -> data_out matches each peripheral byte, peripheral receives each master byte.
REQ-036 100 MHz clk, CLK_DIV=4 -> SCK half-period 40 ns, 16 toggles per frame, CS low for 40 ns before the first edge and 40 ns after the last edge.
REQ-037 Mode 2, rst pulsed mid-frame -> CS=1 and SCK=1 immediately, data_out=0, next frame correct.
REQ-038 With SPI_CONTROLLER_PARITY_EN: send 0xB6, receive 0xB6 -> parity_err=0.
REQ-039 With SPI_CONTROLLER_PARITY_EN: receive 0xB7 -> parity_err=1, held until rst.
